wide_add_sequencer: RTL

- Multi-cycle controller that computes W*K-bit add/subtract by sequencing a shared W-bit carry-lookahead adder, one slice per cycle, LSB slice first; carry is rippled between slices through a register.
- The adder is instantiated next to this block at the integration level and driven through the add_* ports. Its result is combinational, same cycle.
- Sits between the ALU issue logic (valid/ready request) and the writeback stage (valid/ready response).

---
 rtl/wide_add_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract sequencer: a W*K-bit operation runs slice by slice
// on an external W-bit adder, LSB slice first, carry held in a register.
module wide_add_sequencer #(
   parameter int W = 64,
   parameter int K = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W*K-1:0] in_a,
   input  logic [W*K-1:0] in_b,
   input  logic           in_sub,
   input  logic           in_cin,
   output logic [W-1:0]   add_x,
   output logic [W-1:0]   add_y,
   output logic           add_cin,
   input  logic [W:0]     add_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W*K-1:0] out_sum,
   output logic           out_cout,
   output logic           out_ovf,
   output logic           busy
);

   localparam int N  = W * K;
   localparam int IW = $clog2(K);
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    a_reg;
   logic [N-1:0]    b_reg;
   logic [N-W-1:0]  work;
   logic [IW-1:0]   idx;
   logic            carry;
   logic            accept;
   logic            last;
   logic            release_out;
   logic            ovf_nxt;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (idx == LAST) state_nxt = DONE;
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) state_nxt = in_valid ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) in_ready = 1'b0;
   end

   assign accept      = in_valid && in_ready;
   assign last        = (state == RUN) && (idx == LAST);
   assign release_out = (state == DONE) && out_ready;
   assign busy        = (state != IDLE);

   // Adder operands only come from registers, never from add_result.
   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_x   = a_reg[int'(idx)*W +: W];
         add_y   = b_reg[int'(idx)*W +: W];
         add_cin = carry;
      end
   end

   // Final slice MSB is the result MSB; b_reg is already inverted for sub.
   assign ovf_nxt = (a_reg[N-1] ~^ b_reg[N-1])
                  & (add_result[W-1] ^ a_reg[N-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         work      <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            carry <= in_cin ^ in_sub;
            idx   <= '0;
         end else if (state == RUN) begin
            carry <= add_result[W];
            if (last) begin
               idx <= '0;
            end else begin
               work[int'(idx)*W +: W] <= add_result[W-1:0];
               idx <= idx + 1'b1;
            end
         end
         if (last) begin
            out_valid <= 1'b1;
            out_sum   <= {add_result[W-1:0], work};
            out_cout  <= add_result[W];
            out_ovf   <= ovf_nxt;
         end else if (release_out) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
